// File: rtl/dvp_source.sv
// DVP camera-style byte source: RGB565 bytes with pclk, h_ref, v_sync and frame_start on clk_25.
// Define DVP_SOURCE_COLORBAR_EN for an 8-bar colour pattern; otherwise active bytes carry the slot index.
module dvp_source #(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 288,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic       clk_25,
  input  logic       reset_n,
  input  logic       enable,
  output logic       pclk,
  output logic [7:0] data_out,
  output logic       h_ref,
  output logic       v_sync,
  output logic       frame_start
);

  localparam int LINE_SLOTS = H_ACTIVE + H_BLANK;
  localparam int MAX_AS     = (V_ACTIVE > V_SYNC) ? V_ACTIVE : V_SYNC;
  localparam int MAX_FB     = (V_FRONT > V_BACK) ? V_FRONT : V_BACK;
  localparam int MAX_LINES  = (MAX_AS > MAX_FB) ? MAX_AS : MAX_FB;
  localparam int SLOT_W     = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int LINE_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] BACK   = 3'd2;
  localparam logic [2:0] ACTIVE = 3'd3;
  localparam logic [2:0] FRONT  = 3'd4;

  logic [2:0]        state, state_nx;
  logic [SLOT_W-1:0] slot_cnt, slot_nx;
  logic [LINE_W-1:0] line_cnt, line_nx;
  logic              advance;
  logic              h_ref_nx;
  logic              v_sync_nx;
  logic [7:0]        data_nx;

  function automatic int lines_in(input logic [2:0] st);
    int n;
    case (st)
      SYNC:    n = V_SYNC;
      BACK:    n = V_BACK;
      ACTIVE:  n = V_ACTIVE;
      FRONT:   n = V_FRONT;
      default: n = 1;
    endcase
    return n;
  endfunction

  // Zero-length BACK/FRONT regions are skipped; the enable decision is taken only at frame end.
  function automatic logic [2:0] state_after(input logic [2:0] st, input logic en);
    logic [2:0] nx;
    case (st)
      SYNC:    nx = (V_BACK > 0) ? BACK : ACTIVE;
      BACK:    nx = ACTIVE;
      ACTIVE:  nx = (V_FRONT > 0) ? FRONT : (en ? SYNC : IDLE);
      FRONT:   nx = en ? SYNC : IDLE;
      default: nx = IDLE;
    endcase
    return nx;
  endfunction

  // A slot advances when pclk is about to fall, so outputs are stable across each pclk rise.
  always_comb begin
    state_nx = state;
    slot_nx  = slot_cnt;
    line_nx  = line_cnt;
    advance  = (state == IDLE) ? enable : pclk;
    if (state == IDLE) begin
      if (enable) state_nx = SYNC;
    end else if (pclk) begin
      if (32'(slot_cnt) == LINE_SLOTS - 1) begin
        slot_nx = '0;
        if (32'(line_cnt) == lines_in(state) - 1) begin
          line_nx  = '0;
          state_nx = state_after(state, enable);
        end else begin
          line_nx = line_cnt + 1'b1;
        end
      end else begin
        slot_nx = slot_cnt + 1'b1;
      end
    end
  end

  assign h_ref_nx  = (state_nx == ACTIVE) && (32'(slot_nx) < H_ACTIVE);
  assign v_sync_nx = (state_nx == SYNC);

`ifdef DVP_SOURCE_COLORBAR_EN
  localparam int BAR_SLOTS = H_ACTIVE / 8;
  localparam int BAR_PW    = (BAR_SLOTS > 1) ? $clog2(BAR_SLOTS) : 1;

  logic [2:0]        bar, bar_nx;
  logic [BAR_PW-1:0] bar_pos, bar_pos_nx;
  logic [15:0]       bar_color;

  always_comb begin
    bar_nx     = bar;
    bar_pos_nx = bar_pos;
    if (slot_nx == '0) begin
      bar_nx     = '0;
      bar_pos_nx = '0;
    end else if (advance && h_ref_nx) begin
      if (32'(bar_pos) == BAR_SLOTS - 1) begin
        bar_pos_nx = '0;
        if (bar != 3'd7) bar_nx = bar + 1'b1;
      end else begin
        bar_pos_nx = bar_pos + 1'b1;
      end
    end
  end

  always_comb begin
    case (bar_nx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  end

  // Pixels start on even slots, so slot parity selects high byte then low byte.
  assign data_nx = !h_ref_nx ? 8'h00 : (slot_nx[0] ? bar_color[7:0] : bar_color[15:8]);

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      bar     <= '0;
      bar_pos <= '0;
    end else begin
      bar     <= bar_nx;
      bar_pos <= bar_pos_nx;
    end
  end
`else
  assign data_nx = h_ref_nx ? 8'(slot_nx) : 8'h00;
`endif

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      slot_cnt    <= '0;
      line_cnt    <= '0;
      pclk        <= 1'b0;
      h_ref       <= 1'b0;
      v_sync      <= 1'b0;
      data_out    <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      slot_cnt    <= slot_nx;
      line_cnt    <= line_nx;
      pclk        <= (state != IDLE && state_nx != IDLE) ? ~pclk : 1'b0;
      h_ref       <= h_ref_nx;
      v_sync      <= v_sync_nx;
      data_out    <= data_nx;
      frame_start <= advance && (state_nx == SYNC) && (state != SYNC);
    end
  end

endmodule

// File: tb/tb_dvp_source.sv
// Self-checking bench for dvp_source using a small-frame configuration and an arithmetic frame model.
module tb_dvp_source;

  localparam int HA = 16, HB = 4, VA = 2, VS = 1, VB = 1, VF = 1;
  localparam int LS    = HA + HB;
  localparam int FRAME = 2 * LS * (VS + VB + VA + VF);

  logic       clk_25  = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable  = 1'b0;
  logic       pclk, h_ref, v_sync, frame_start;
  logic [7:0] data_out;
  logic [11:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 clk_25 = ~clk_25;

  dvp_source #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk_25(clk_25),
    .reset_n(reset_n),
    .enable(enable),
    .pclk(pclk),
    .data_out(data_out),
    .h_ref(h_ref),
    .v_sync(v_sync),
    .frame_start(frame_start)
  );

  // {pclk, h_ref, v_sync, frame_start, data_out}
  assign obs = {pclk, h_ref, v_sync, frame_start, data_out};

  // Expected outputs k clk_25 cycles after the frame_start cycle, from the frame geometry alone.
  function automatic logic [11:0] exp_out(input int k);
    int slot, ln, s;
    logic hr, vs, pc, fs;
    logic [7:0] d;
`ifdef DVP_SOURCE_COLORBAR_EN
    logic [15:0] colors [8];
    colors = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif
    slot = k / 2;
    ln   = slot / LS;
    s    = slot % LS;
    pc   = (k % 2) == 1;
    fs   = (k == 0);
    vs   = ln < VS;
    hr   = (ln >= VS + VB) && (ln < VS + VB + VA) && (s < HA);
    d    = 8'h00;
    if (hr) begin
`ifdef DVP_SOURCE_COLORBAR_EN
      d = ((s % 2) == 0) ? colors[s / (HA / 8)][15:8] : colors[s / (HA / 8)][7:0];
`else
      d = 8'(s % 256);
`endif
    end
    return {pc, hr, vs, fs, d};
  endfunction

  task automatic tick;
    @(posedge clk_25);
    #1;
  endtask

  task automatic test_reset;
    int n;
    enable = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h want=%h", obs, 12'h000);
    end
    tick;
    reset_n = 1'b1;
    n = 8 + $urandom_range(0, 12);
    for (int i = 0; i < n; i++) begin
      tick;
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("[TB] FAIL idle_without_enable cyc=%0d got=%h want=%h", i, obs, 12'h000);
      end
    end
  endtask

  task automatic test_frames;
    logic [11:0] prev, want;
    int vs_hi, runs, run_len, fs_cnt, last_fs;
    vs_hi = 0; runs = 0; run_len = 0; fs_cnt = 0; last_fs = -1;
    prev = obs;
    repeat ($urandom_range(0, 5)) tick;
    prev = obs;
    enable = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick;
      want = exp_out(k % FRAME);
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL frame_cycle k=%0d got=%h want=%h", k, obs, want);
      end
      if (pclk && !prev[11]) begin
        total++;
        if ({obs[10:9], obs[7:0]} !== {prev[10:9], prev[7:0]}) begin
          bad++;
          $display("[TB] FAIL stable_at_pclk_rise k=%0d got=%h prev=%h", k, obs, prev);
        end
      end
      if (v_sync) vs_hi++;
      if (h_ref) run_len++;
      else if (run_len > 0) begin
        runs++;
        total++;
        if (run_len !== 32) begin
          bad++;
          $display("[TB] FAIL href_run_length got=%0d want=%0d", run_len, 32);
        end
        run_len = 0;
      end
      if (frame_start) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          total++;
          if (k - last_fs !== 200) begin
            bad++;
            $display("[TB] FAIL frame_start_period got=%0d want=%0d", k - last_fs, 200);
          end
        end
        last_fs = k;
      end
      prev = obs;
    end
    total++;
    if (vs_hi !== 2 * 40) begin
      bad++;
      $display("[TB] FAIL vsync_high_cycles got=%0d want=%0d", vs_hi, 80);
    end
    total++;
    if (runs !== 4) begin
      bad++;
      $display("[TB] FAIL href_run_count got=%0d want=%0d", runs, 4);
    end
    total++;
    if (fs_cnt !== 2) begin
      bad++;
      $display("[TB] FAIL frame_start_count got=%0d want=%0d", fs_cnt, 2);
    end
  endtask

  task automatic test_enable_drop;
    logic [11:0] want;
    int drop;
    enable = 1'b0;
    #2 reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    repeat ($urandom_range(1, 6)) tick;
    enable = 1'b1;
    drop = 2 * 2 * LS * (VS + VB) + 2 * $urandom_range(0, HA - 1);
    for (int k = 0; k < FRAME; k++) begin
      tick;
      want = exp_out(k);
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL drop_frame k=%0d got=%h want=%h", k, obs, want);
      end
      if (k == drop) enable = 1'b0;
    end
    for (int i = 0; i < 3 * FRAME / 2; i++) begin
      tick;
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("[TB] FAIL idle_after_drop cyc=%0d got=%h want=%h", i, obs, 12'h000);
      end
    end
  endtask

  task automatic test_reset_mid_active;
    logic [11:0] want;
    int stop;
    enable = 1'b0;
    #2 reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    enable = 1'b1;
    stop = 2 * 2 * LS * (VS + VB) + $urandom_range(0, 2 * HA - 1);
    for (int k = 0; k <= stop; k++) begin
      tick;
      want = exp_out(k);
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL pre_reset k=%0d got=%h want=%h", k, obs, want);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_mid_active got=%h want=%h", obs, 12'h000);
    end
    tick;
    tick;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_held got=%h want=%h", obs, 12'h000);
    end
    reset_n = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      tick;
      want = exp_out(k % FRAME);
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL restart_frame k=%0d got=%h want=%h", k, obs, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_enable_drop();
    test_reset_mid_active();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
